// File: rtl/led_ring_monitor_pkg.sv
// Shared definitions for the LED ring receive-side blocks: state encoding,
// counter width and the modular ring step used to predict the next position.
package ledring_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int CNT_W = 8;

  // Wrap is explicit so non power-of-two ring sizes step correctly.
  function automatic int unsigned next_idx(input int unsigned pos,
                                           input logic dir,
                                           input int unsigned width);
    int unsigned nxt;
    if (dir) begin
      nxt = (pos == width - 32'd1) ? 32'd0 : pos + 32'd1;
    end else begin
      nxt = (pos == 32'd0) ? width - 32'd1 : pos - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/led_ring_monitor_if.sv
// Bundle between an LED ring source (master) and the ring monitor (slave).
interface led_ring_monitor_if #(parameter int WIDTH = 8);
  import ledring_pkg::*;

  localparam int PW = $clog2(WIDTH);

  logic [WIDTH-1:0] led_in;
  logic [PW-1:0]    pos;
  logic             valid;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] lap_cnt;

  modport master (output led_in,
                  input  pos, valid, locked, err, err_cnt, lap_cnt);

  modport slave  (input  led_in,
                  output pos, valid, locked, err, err_cnt, lap_cnt);

endinterface

// File: rtl/led_ring_monitor_onecold.sv
// One-cold decoder: flags patterns with exactly one low bit and reports
// the index of that bit.
module onecold_decode #(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] led,
  output logic             legal,
  output logic [IW-1:0]    idx
);

  logic [4:0] zeros_s;

  // Count low bits and remember where the (last) low bit sits.
  always_comb begin
    zeros_s = 5'd0;
    idx     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!led[i]) begin
        zeros_s = zeros_s + 5'd1;
        idx     = IW'(i);
      end else begin
        zeros_s = zeros_s;
      end
    end
    legal = (zeros_s == 5'd1);
  end

endmodule

// File: rtl/led_ring_monitor.sv
// Receive-side LED ring monitor: decodes the one-cold position, tracks
// rotation legality, and reports lock, errors and completed laps.
import ledring_pkg::*;

module led_ring_monitor #(
  parameter int WIDTH    = 8,
  parameter int DIR      = 0,
  parameter int LOCK_N   = 3,
  parameter int UNLOCK_N = 2
) (
  input  logic               clk1h,
  input  logic               rst,
  led_ring_monitor_if.slave  bus
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0]    WRAP_C     = (DIR != 0) ? PW'(WIDTH - 1) : '0;
  localparam logic [CNT_W-1:0] LOCK_N_C   = CNT_W'(LOCK_N);
  localparam logic [CNT_W-1:0] UNLOCK_N_C = CNT_W'(UNLOCK_N);

  state_t           state_r;
  logic [PW-1:0]    pos_r;
  logic             valid_r;
  logic             locked_r;
  logic             err_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] lap_cnt_r;
  logic [CNT_W-1:0] good_cnt_r;
  logic [CNT_W-1:0] bad_cnt_r;

  logic             legal_s;
  logic [PW-1:0]    idx_s;
  logic [PW-1:0]    exp_s;
  logic             good_s;

  onecold_decode #(.WIDTH(WIDTH), .IW(PW)) u_decode (
    .led   (bus.led_in),
    .legal (legal_s),
    .idx   (idx_s)
  );

  assign exp_s  = PW'(next_idx(32'(pos_r), (DIR != 0), 32'(WIDTH)));
  assign good_s = legal_s && (idx_s == exp_s);

  // Lock state machine with registered status, counters and position.
  always_ff @(posedge clk1h or negedge rst) begin
    if (!rst) begin
      state_r    <= HUNT;
      pos_r      <= '0;
      valid_r    <= 1'b0;
      locked_r   <= 1'b0;
      err_r      <= 1'b0;
      err_cnt_r  <= '0;
      lap_cnt_r  <= '0;
      good_cnt_r <= '0;
      bad_cnt_r  <= '0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        HUNT: begin
          if (legal_s) begin
            pos_r      <= idx_s;
            valid_r    <= 1'b1;
            good_cnt_r <= 8'd1;
            bad_cnt_r  <= '0;
            if (LOCK_N_C == 8'd1) begin
              state_r  <= LOCKED;
              locked_r <= 1'b1;
            end else begin
              state_r  <= ACQ;
            end
          end else begin
            valid_r <= 1'b0;
          end
        end
        ACQ: begin
          if (good_s) begin
            pos_r      <= idx_s;
            valid_r    <= 1'b1;
            good_cnt_r <= good_cnt_r + 8'd1;
            if (good_cnt_r + 8'd1 >= LOCK_N_C) begin
              state_r   <= LOCKED;
              locked_r  <= 1'b1;
              bad_cnt_r <= '0;
            end else begin
              state_r   <= ACQ;
            end
          end else if (legal_s) begin
            pos_r      <= idx_s;
            valid_r    <= 1'b1;
            good_cnt_r <= 8'd1;
          end else begin
            valid_r    <= 1'b0;
            good_cnt_r <= '0;
            state_r    <= HUNT;
          end
        end
        LOCKED: begin
          if (good_s) begin
            pos_r     <= idx_s;
            valid_r   <= 1'b1;
            bad_cnt_r <= '0;
            if (pos_r == WRAP_C) begin
              lap_cnt_r <= lap_cnt_r + 8'd1;
            end else begin
              lap_cnt_r <= lap_cnt_r;
            end
          end else begin
            // Flywheel: keep predicting so the next check compares against the expected step.
            err_r   <= 1'b1;
            valid_r <= legal_s;
            pos_r   <= exp_s;
            if (err_cnt_r != 8'hFF) begin
              err_cnt_r <= err_cnt_r + 8'd1;
            end else begin
              err_cnt_r <= err_cnt_r;
            end
            if (bad_cnt_r + 8'd1 >= UNLOCK_N_C) begin
              bad_cnt_r  <= '0;
              good_cnt_r <= '0;
              locked_r   <= 1'b0;
              state_r    <= HUNT;
            end else begin
              bad_cnt_r  <= bad_cnt_r + 8'd1;
            end
          end
        end
        default: begin
          state_r    <= HUNT;
          locked_r   <= 1'b0;
          valid_r    <= 1'b0;
          good_cnt_r <= '0;
          bad_cnt_r  <= '0;
        end
      endcase
    end
  end

  assign bus.pos     = pos_r;
  assign bus.valid   = valid_r;
  assign bus.locked  = locked_r;
  assign bus.err     = err_r;
  assign bus.err_cnt = err_cnt_r;
  assign bus.lap_cnt = lap_cnt_r;

endmodule
